// File: rtl/mul2add_pkg.sv
// Shared arithm-group definitions: FSM encoding and default operand width
// (common to the divider and mul2add).
package mul2add_pkg;

  localparam int ARITHM_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } arithm_state_t;

endpackage

// File: rtl/mul2add_shreg.sv
// (W+1)-bit left shift register with synchronous clear and serial LSB input.
module mul2add_shreg #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       sin,
  output logic [W:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        q <= '0;
    else if (clear)    q <= '0;
    else if (shift_en) q <= {q[W-1:0], sin};
  end

endmodule

// File: rtl/mul2add.sv
// Bit-serial rebuild of a = 2*div2 + mod2 (Horner, MSB first) on the
// activate/endop handshake. Define MUL2ADD_BUSY_EN to add the busy output.
module mul2add
  import mul2add_pkg::*;
#(
  parameter int W  = ARITHM_W,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         activate,
  input  logic [W-1:0] div2,
  input  logic         mod2,
  output logic [W-1:0] a,
  output logic         carry,
  output logic         endop
`ifdef MUL2ADD_BUSY_EN
  ,
  output logic         busy
`endif
);

  arithm_state_t state;
  logic [CW-1:0] cnt;
  logic [W:0]    op_q;
  logic [W:0]    op_sh;
  logic [W:0]    wk;
  logic          start;
  logic          shift_en;

  assign start    = (state == IDLE) && activate;
  assign shift_en = (state == SHIFT);
  // Walking op_q left by cnt presents op_q[W-cnt] at the MSB.
  assign op_sh    = op_q << cnt;

  mul2add_shreg #(.W(W)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .shift_en (shift_en),
    .sin      (op_sh[W]),
    .q        (wk)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a     <= '0;
      carry <= 1'b0;
      endop <= 1'b0;
    end else begin
      endop <= 1'b0;
      case (state)
        IDLE: begin
          if (activate) begin
            op_q  <= {div2, mod2};
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Final shift parks cnt at 0 so it never runs past W.
          if (cnt == CW'(W)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          a     <= wk[W-1:0];
          carry <= wk[W];
          endop <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL2ADD_BUSY_EN
  assign busy = (state == SHIFT) || (state == DONE);
`endif

endmodule
